// File: rtl/uart_tx_queue_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : uart_tx_queue_pkg
// Purpose  : Shared definitions for the UART transmit queue: launch FSM state
//            encodings and the UART byte / bus data widths.
// Ports    : none (package)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package uart_tx_queue_pkg;

   localparam int UART_DATA_W = 8;
   localparam int UART_BUS_W  = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_DRAIN  = 2'd2
   } uart_q_state_e;

endpackage : uart_tx_queue_pkg
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : uart_sync_fifo
// Purpose  : Single-clock byte FIFO with a combinational head read and a
//            separate occupancy counter. Pointers wrap naturally.
// Ports    : sys_clk, sys_rst_n    - clock, async active-low reset
//            push, din             - write strobe and byte (ignored when full)
//            pop, dout             - read strobe (ignored when empty), head byte
//            full, empty, level    - occupancy status
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module uart_sync_fifo
   import uart_tx_queue_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic [UART_DATA_W-1:0] din,
   output logic [UART_DATA_W-1:0] dout,
   output logic                   full,
   output logic                   empty,
   output logic [LVL_W-1:0]       level
);

   localparam int               PTR_W   = $clog2(DEPTH);
   localparam logic [LVL_W-1:0] C_DEPTH = LVL_W'(DEPTH);

   logic [UART_DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]       r_wr_ptr;
   logic [PTR_W-1:0]       r_rd_ptr;
   logic [LVL_W-1:0]       r_level;
   logic                   w_do_push;
   logic                   w_do_pop;

   // Status is taken from the current occupancy, so a push into a full FIFO
   // is refused even if a pop frees an entry on the same edge.
   assign w_do_push = push & ~full;
   assign w_do_pop  = pop & ~empty;

   // Storage carries no reset: contents are don't-care after reset.
   always_ff @(posedge sys_clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_level <= r_level + LVL_W'(1);
            2'b01:   r_level <= r_level - LVL_W'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   assign dout  = r_mem[r_rd_ptr];
   assign full  = (r_level == C_DEPTH);
   assign empty = (r_level == '0);
   assign level = r_level;

endmodule : uart_sync_fifo
`default_nettype wire

// File: rtl/uart_tx_queue.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : uart_tx_queue
// Purpose  : Byte queue and launch controller in front of the UART
//            transmitter. Bus writes are queued; the FSM pops one byte at a
//            time and drives the transmitter's uart_en / uart_din handshake.
// Ports    : sys_clk, sys_rst_n    - clock, async active-low reset
//            wr_en, wr_data        - bus write strobe / data ([7:0] queued)
//            clr_ovf               - clears the sticky overflow flag
//            full, empty, level    - queue status
//            ovf                   - sticky: a write was dropped while full
//            idle                  - queue empty, FSM idle, transmitter idle
//            uart_en, uart_din     - registered start request and byte
//            uart_tx_busy          - transmitter frame-in-progress
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module uart_tx_queue
   import uart_tx_queue_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   input  logic                  wr_en,
   input  logic [UART_BUS_W-1:0] wr_data,
   input  logic                  clr_ovf,
   output logic                  full,
   output logic                  empty,
   output logic [LVL_W-1:0]      level,
   output logic                  ovf,
   output logic                  idle,
   output logic                  uart_en,
   output logic [UART_BUS_W-1:0] uart_din,
   input  logic                  uart_tx_busy
);

   uart_q_state_e          r_state;
   logic                   r_uart_en;
   logic [UART_BUS_W-1:0]  r_uart_din;
   logic                   r_ovf;
   logic [UART_DATA_W-1:0] w_head;
   logic                   w_full;
   logic                   w_empty;
   logic [LVL_W-1:0]       w_level;
   logic                   w_pop;
   logic                   w_unused_wr_hi;

   // Only the low byte of a bus write is queued.
   assign w_unused_wr_hi = &{1'b0, wr_data[UART_BUS_W-1:UART_DATA_W]};

   // Pop in the same cycle the launch is registered, so level drops on the
   // edge where uart_en rises.
   assign w_pop = (r_state == ST_IDLE) & ~w_empty & ~uart_tx_busy;

   uart_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .LVL_W (LVL_W)
   ) u_fifo (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .push      (wr_en),
      .pop       (w_pop),
      .din       (wr_data[UART_DATA_W-1:0]),
      .dout      (w_head),
      .full      (w_full),
      .empty     (w_empty),
      .level     (w_level)
   );

   // Launch FSM. uart_din is only written on a pop, so it stays stable from
   // LAUNCH entry until the next launch, covering the transmitter's
   // two-flop capture delay. uart_en drops as soon as busy is seen, so the
   // next launch always presents a fresh rising edge.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state    <= ST_IDLE;
         r_uart_en  <= 1'b0;
         r_uart_din <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_pop) begin
                  r_uart_din <= {{(UART_BUS_W-UART_DATA_W){1'b0}}, w_head};
                  r_uart_en  <= 1'b1;
                  r_state    <= ST_LAUNCH;
               end
            end
            ST_LAUNCH: begin
               if (uart_tx_busy) begin
                  r_uart_en <= 1'b0;
                  r_state   <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               r_uart_en <= 1'b0;
               if (!uart_tx_busy) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_uart_en <= 1'b0;
               r_state   <= ST_IDLE;
            end
         endcase
      end
   end

   // Sticky overflow; a dropped write beats a simultaneous clear.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_ovf <= 1'b0;
      end else if (wr_en && w_full) begin
         r_ovf <= 1'b1;
      end else if (clr_ovf) begin
         r_ovf <= 1'b0;
      end
   end

   assign full     = w_full;
   assign empty    = w_empty;
   assign level    = w_level;
   assign ovf      = r_ovf;
   assign idle     = w_empty & (r_state == ST_IDLE) & ~uart_tx_busy;
   assign uart_en  = r_uart_en;
   assign uart_din = r_uart_din;

endmodule : uart_tx_queue
`default_nettype wire

// File: tb/tb_uart_tx_queue.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_uart_tx_queue
// Purpose  : Self-checking bench for uart_tx_queue with a behavioural
//            transmitter and a queue-based reference model.
// Ports    : none
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_uart_tx_queue;

   localparam int DEPTH     = 16;
   localparam int LW        = 5;
   localparam int FRAME_CYC = 20;

   logic          sys_clk = 1'b0;
   logic          sys_rst_n = 1'b0;
   logic          wr_en = 1'b0;
   logic [31:0]   wr_data = '0;
   logic          clr_ovf = 1'b0;
   logic          full, empty, ovf, idle, uart_en;
   logic [LW-1:0] level;
   logic [31:0]   uart_din;
   logic          uart_tx_busy;

   always #5 sys_clk = ~sys_clk;

   uart_tx_queue #(.FIFO_DEPTH(DEPTH), .LVL_W(LW)) dut (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .clr_ovf      (clr_ovf),
      .full         (full),
      .empty        (empty),
      .level        (level),
      .ovf          (ovf),
      .idle         (idle),
      .uart_en      (uart_en),
      .uart_din     (uart_din),
      .uart_tx_busy (uart_tx_busy)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // ---------------- behavioural transmitter ----------------
   logic       tx_s1, tx_s2, model_busy;
   logic [7:0] tx_byte;
   int         tx_cnt;
   bit         hold_busy = 0;
   logic [7:0] rx_log[$];

   assign uart_tx_busy = model_busy | hold_busy;

   always @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         tx_s1 <= 1'b0; tx_s2 <= 1'b0; model_busy <= 1'b0; tx_cnt <= 0; tx_byte <= '0;
      end else begin
         tx_s1 <= uart_en;
         tx_s2 <= tx_s1;
         if (!model_busy && tx_s1 && !tx_s2) begin
            model_busy <= 1'b1;
            tx_byte    <= uart_din[7:0];
            tx_cnt     <= FRAME_CYC - 1;
            rx_log.push_back(uart_din[7:0]);
         end else if (model_busy) begin
            if (tx_cnt == 0) model_busy <= 1'b0;
            else             tx_cnt <= tx_cnt - 1;
         end
      end
   end

   // ---------------- reference model ----------------
   logic [7:0] exp_q[$];
   int  m_level = 0;
   bit  m_ovf = 0;
   int  cyc = 0;
   int  last_push_cyc = 0;

   always @(posedge sys_clk) begin
      cyc++;
      if (sys_rst_n) begin
         if (wr_en) begin
            if (m_level == DEPTH) m_ovf = 1;
            else begin
               exp_q.push_back(wr_data[7:0]);
               m_level++;
               last_push_cyc = cyc;
            end
         end else if (clr_ovf) m_ovf = 0;
      end
   end

   // ---------------- monitor ----------------
   bit         mon_on = 0;
   bit         prev_en = 0, prev_busy = 0, prev_mbusy = 0, in_frame = 0, gap_armed = 0;
   logic [7:0] cur_byte = '0;
   int         en_rise_cyc, en_fall_cyc, busy_rise_cyc, busy_fall_cyc, max_level;

   always @(negedge sys_clk) begin
      if (mon_on && sys_rst_n) begin
         if (uart_en && !prev_en) begin
            en_rise_cyc = cyc;
            m_level--;
            if (gap_armed) chk_eq("frame_gap", cyc - busy_fall_cyc, 2);
            gap_armed = 0;
            if (exp_q.size() == 0) chk_eq("spurious_launch", 1, 0);
            else begin
               chk_eq("launch_din", uart_din, {24'd0, exp_q[0]});
               cur_byte = exp_q.pop_front();
            end
            in_frame = 1;
         end
         if (!uart_en && prev_en) en_fall_cyc = cyc;
         if (uart_tx_busy && !prev_busy) busy_rise_cyc = cyc;
         if (model_busy && !prev_mbusy) chk_eq("tx_latch", tx_byte, cur_byte);
         if (in_frame) chk_eq("din_stable", uart_din, {24'd0, cur_byte});
         if (!model_busy && prev_mbusy && !hold_busy) begin
            busy_fall_cyc = cyc;
            in_frame = 0;
            gap_armed = (m_level > 0);
         end
         chk_eq("level", level, m_level);
         chk_eq("empty", empty, m_level == 0);
         chk_eq("full", full, m_level == DEPTH);
         chk_eq("ovf", ovf, m_ovf);
         if (level > max_level) max_level = level;
         prev_en = uart_en; prev_busy = uart_tx_busy; prev_mbusy = model_busy;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic push_byte(input logic [7:0] b);
      wr_en = 1'b1; wr_data = {$urandom_range(0, 32'hFFFFFF), b};
      @(posedge sys_clk); #1;
      wr_en = 1'b0;
   endtask

   task automatic wait_idle(input int bound);
      int k;
      for (k = 0; k < bound; k++) begin
         @(negedge sys_clk);
         if (idle && !uart_en && !model_busy && exp_q.size() == 0) break;
      end
      if (k == bound) chk_eq("idle_timeout", 0, 1);
      #1;
   endtask

   task automatic do_reset();
      mon_on = 0;
      #2 sys_rst_n = 1'b0;
      exp_q.delete(); m_level = 0; m_ovf = 0;
      prev_en = 0; prev_busy = 0; prev_mbusy = 0; in_frame = 0; gap_armed = 0;
      repeat (3) @(posedge sys_clk);
      #1 sys_rst_n = 1'b1;
      mon_on = 1;
   endtask

   task automatic chk_rx(input string tag, input logic [7:0] want[$]);
      chk_eq({tag, "_count"}, rx_log.size(), want.size());
      for (int i = 0; i < want.size() && i < rx_log.size(); i++)
         chk_eq(tag, rx_log[i], want[i]);
   endtask

   logic [7:0] want[$];

   initial begin
      // Reset state
      do_reset();
      @(negedge sys_clk);
      chk_eq("rst_uart_en", uart_en, 0);
      chk_eq("rst_uart_din", uart_din, 0);
      chk_eq("rst_empty", empty, 1);
      chk_eq("rst_level", level, 0);
      chk_eq("rst_ovf", ovf, 0);
      chk_eq("rst_idle", idle, 1);

      // Single byte with latency checks
      @(posedge sys_clk); #1;
      rx_log.delete();
      push_byte(8'h55);
      wait_idle(200);
      chk_eq("lat_en_rise", en_rise_cyc - last_push_cyc, 1);
      chk_eq("lat_busy_rise", busy_rise_cyc - last_push_cyc, 3);
      chk_eq("lat_en_fall", en_fall_cyc - busy_rise_cyc, 1);
      want = '{8'h55};
      chk_rx("single", want);

      // Burst of five consecutive writes
      rx_log.delete(); max_level = 0;
      for (int i = 1; i <= 5; i++) push_byte(8'(i));
      wait_idle(400);
      chk_eq("burst_peak_ok", (max_level >= 4 && max_level <= 5), 1);
      want = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      chk_rx("burst", want);
      chk_eq("burst_idle", idle, 1);

      // Overflow with the transmitter held busy
      rx_log.delete(); want.delete();
      hold_busy = 1;
      @(posedge sys_clk); #1;
      for (int i = 0; i < DEPTH; i++) begin
         logic [7:0] b;
         b = 8'($urandom);
         want.push_back(b);
         push_byte(b);
      end
      @(negedge sys_clk);
      chk_eq("ovf_full16", full, 1);
      chk_eq("ovf_not_yet", ovf, 0);
      push_byte(8'($urandom));
      @(negedge sys_clk);
      chk_eq("ovf_set", ovf, 1);
      chk_eq("ovf_level", level, DEPTH);
      wr_en = 1; clr_ovf = 1; wr_data = 32'hAA;
      @(posedge sys_clk); #1;
      wr_en = 0;
      @(negedge sys_clk);
      chk_eq("ovf_set_wins", ovf, 1);
      @(posedge sys_clk); #1;
      clr_ovf = 0;
      @(negedge sys_clk);
      chk_eq("ovf_cleared", ovf, 0);
      hold_busy = 0;
      wait_idle(2000);
      chk_rx("ovf_stream", want);

      // Wrap: 40 bytes with random gaps, pushes interleaved with pops
      rx_log.delete(); want.delete(); max_level = 0;
      @(posedge sys_clk); #1;
      for (int i = 0; i < 40; i++) begin
         logic [7:0] b;
         int k;
         repeat ($urandom_range(0, 20)) begin
            clr_ovf = ($urandom_range(0, 7) == 0);
            @(posedge sys_clk); #1;
         end
         clr_ovf = 0;
         for (k = 0; k < 100 && full; k++) begin @(posedge sys_clk); #1; end
         if (k == 100) chk_eq("wrap_full_timeout", 0, 1);
         b = 8'($urandom);
         want.push_back(b);
         push_byte(b);
      end
      wait_idle(3000);
      chk_rx("wrap", want);
      chk_eq("wrap_max_level_ok", max_level <= DEPTH, 1);

      // Reset mid-frame with three bytes queued
      rx_log.delete();
      for (int i = 0; i < 4; i++) push_byte(8'(8'hC0 + i));
      begin
         int k;
         for (k = 0; k < 20; k++) begin
            @(negedge sys_clk);
            if (uart_tx_busy) break;
         end
         if (k == 20) chk_eq("midrst_busy_timeout", 0, 1);
      end
      chk_eq("midrst_level3", level, 3);
      do_reset();
      @(negedge sys_clk);
      chk_eq("midrst_empty", empty, 1);
      chk_eq("midrst_level", level, 0);
      chk_eq("midrst_uart_en", uart_en, 0);
      rx_log.delete();
      repeat (60) @(negedge sys_clk);
      chk_eq("midrst_no_frames", rx_log.size(), 0);
      chk_eq("midrst_idle", idle, 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule : tb_uart_tx_queue
`default_nettype wire

// File: doc/uart_tx_queue.md
# uart_tx_queue

Byte queue and launch controller sitting directly upstream of the UART transmitter on the peripheral bus. Bus writes push bytes into an internal FIFO. The block pops one byte at a time and drives the transmitter's `uart_en`/`uart_din` handshake. It honours the transmitter's rising-edge-triggered start and its `uart_tx_busy` flag, so back-to-back bus writes become back-to-back UART frames with no software polling.

## Interface
- `FIFO_DEPTH`, 16: byte entries; a power of two, ≥2.
- `LVL_W`, `$clog2(FIFO_DEPTH)+1`: width of `level`.
- `sys_clk` input 1: system clock; the single clock domain.
- `sys_rst_n` input 1: asynchronous active-low reset.
- `wr_en` input 1: bus write strobe; one byte pushed per cycle in which it is high.
- `wr_data` input 32: bus write data; only `[7:0]` is queued.
- `clr_ovf` input 1: clears `ovf`.
- `full` output 1: FIFO holds `FIFO_DEPTH` bytes.
- `empty` output 1: FIFO holds 0 bytes.
- `level` output `LVL_W`: current occupancy, 0..`FIFO_DEPTH`.
- `ovf` output 1: sticky flag; a write was dropped because the FIFO was full.
- `idle` output 1: `empty` & state==IDLE & !`uart_tx_busy`.
- `uart_en` output 1: transmitter start request, registered.
- `uart_din` output 32: byte to transmit in `[7:0]`, `[31:8]`=0; registered.
- `uart_tx_busy` input 1: transmitter frame-in-progress flag.

## Operation
- Push: on `wr_en` & !`full`, `wr_data[7:0]` is written at `wr_ptr`, then `wr_ptr`++.
- Overflow: on `wr_en` & `full`, the data is discarded and `ovf`<=1.
  - `full` is evaluated on the current occupancy. A push while full is rejected even if a pop occurs in the same cycle.
- `clr_ovf` & overflow in the same cycle: `ovf` stays 1 (set wins).
- Simultaneous push and pop: both take effect and `level` is unchanged.
- Pointers are `$clog2(FIFO_DEPTH)` bits wide and wrap naturally. `level` is a separate counter.
- FSM states:
  - IDLE: if !`empty` & !`uart_tx_busy`, pop the head. Next cycle `uart_din`<={24'd0, head}, `uart_en`<=1 → LAUNCH.
  - LAUNCH: hold `uart_en`=1 and `uart_din` stable. When `uart_tx_busy`=1, `uart_en`<=0 → DRAIN.
  - DRAIN: `uart_en`=0. When `uart_tx_busy`=0 → IDLE.
- The transmitter latches data on the `uart_en` rising edge after a two-flop delay. `uart_din` therefore stays stable from LAUNCH entry through DRAIN exit.
- `uart_en` is low for the whole frame, so every launch produces a clean rising edge.
- Reset: all outputs and state are cleared.
  - `uart_en`=0, `uart_din`=0, `empty`=1, `full`=0, `level`=0, `ovf`=0, state=IDLE.
  - FIFO contents become don't-care.
  - Reset mid-frame drops the queue. The transmitter has its own reset and is reset together with this block.

## Timing
- Push at edge t: `level`, `empty` and `full` update at t; the byte is poppable in the cycle after t.
- Empty queue, idle transmitter, write at edge t0:
  - IDLE sees !`empty` after t0.
  - `uart_en`=1 from edge t0+1.
  - Transmitter captures the rising edge; `uart_tx_busy` rises at t0+3.
  - `uart_en` falls at t0+4.
- Frame to next frame: DRAIN→IDLE one cycle after busy falls; next `uart_en` rise one cycle later. Gap between frames ≤3 cycles beyond the stop bit.
- `level` decrements on the pop edge, i.e. the edge at which `uart_en` rises.
- LAUNCH has no timeout; a transmitter that never asserts busy stalls the queue.

## Structure
- Shared package holds:
  - state encodings `ST_IDLE`=2'd0, `ST_LAUNCH`=2'd1, `ST_DRAIN`=2'd2;
  - the `UART_DATA_W`=8 constant.
- One sub-module, `uart_sync_fifo`: single-clock FIFO, 8-bit wide, parameterised by depth.
  - Ports: push, pop, din, dout, full, empty, level.
  - Read is combinational head.
- The top level holds the FSM, the `ovf` flag and the output registers.

## Test plan
- Reset: after `sys_rst_n` low→high, expect `uart_en`=0, `uart_din`=0, `empty`=1, `level`=0, `ovf`=0, `idle`=1.
- Single byte: write 0x55 to a behavioural transmitter model.
  - Expect `uart_en` to rise 1 cycle after the write and to fall 1 cycle after busy.
  - Expect `uart_din`=0x00000055 throughout the frame and a serial frame of 0x55.
- Burst of 5 (0x01..0x05) in consecutive cycles: expect `level` to peak at 4 or 5, five frames in order, `idle`=1 at the end, and no byte lost or duplicated.
- Overflow at `FIFO_DEPTH`=16 with busy held high: 17 writes.
  - Expect `full`=1 after the 16th write and `ovf`=1 after the 17th.
  - Expect the 17th byte absent from the output stream.
  - `clr_ovf` then clears `ovf`.
- Wrap: 40 bytes streamed through depth 16, with pushes interleaved with pops; expect exact in-order output and `level` never exceeding 16.
- Reset mid-frame: with 3 bytes queued and busy high, assert reset; expect the queue empty and `uart_en`=0 after release, and no further frames.
